// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI4-Lite traffic checker.
//   tg_state_e   : run-sequencer states
//   RESP_*       : AXI response encodings
//   LFSR_POLY    : right-shift Galois mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED : default nonzero LFSR seed
//   lfsr_step    : one advance of the data generator
package axi_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW_W,
    ST_B,
    ST_RD_INIT,
    ST_AR,
    ST_R,
    ST_DONE
  } tg_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/axi_tg_lfsr.sv
// 32-bit Galois LFSR used as the pattern source for both write and read phases.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (state returns to SEED)
//   load      : reload SEED (has priority over advance)
//   advance   : step the sequence once
//   state     : current 32-bit pattern
module axi_tg_lfsr
  import axi_tg_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/axi_lite_traffic_checker.sv
// AXI4-Lite manager-side built-in traffic checker. Writes num_txn LFSR beats
// starting at base_addr, reads them back and compares, counting response
// errors, data mismatches and handshake timeouts.
// Ports:
//   ACLK, ARESET        : clock, synchronous active-high reset
//   start               : 1-cycle run request (ignored while busy)
//   base_addr, num_txn  : run parameters, sampled on an accepted start
//   busy, done, pass    : run status (pass qualified by done)
//   timeout, err_cnt    : failure diagnostics
//   AW*/W*/B*/AR*/R*    : AXI4-Lite manager interface
module axi_lite_traffic_checker
  import axi_tg_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 64,
  parameter int          CNT_W       = 16,
  parameter int          ERR_W       = 16,
  parameter int          STRIDE      = DATA_W / 8,
  parameter logic [31:0] SEED        = DEFAULT_SEED,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_txn,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [ERR_W-1:0]    err_cnt,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  tg_state_e             state, state_nx;
  logic [ADDR_W-1:0]     base_q, addr_q, sel_base;
  logic [CNT_W-1:0]      num_q, idx_q, sel_num;
  logic                  aw_done, w_done;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  done_q, timeout_q, start_pend;
  logic [ERR_W-1:0]      err_q;
  logic [31:0]           lfsr_q;
  logic [DATA_W-1:0]     pattern;
  logic                  aw_hs, w_hs, b_hs, r_hs, ar_hs;
  logic                  start_go, last_beat, timed_out, tmo_hit, err_inc;
  logic                  beat_adv, lfsr_load;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign b_hs  = (state == ST_B) && BVALID;
  assign r_hs  = (state == ST_R) && RVALID;

  // A start seen during the DONE cycle is remembered and serviced from IDLE.
  assign start_go  = (state == ST_IDLE) && (start || start_pend);
  assign sel_base  = start ? base_addr : base_q;
  assign sel_num   = start ? num_txn : num_q;
  assign last_beat = (idx_q == num_q - CNT_W'(1));
  assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
  assign beat_adv  = b_hs || r_hs;
  assign lfsr_load = start_go || (state == ST_RD_INIT);
  assign pattern   = {(DATA_W / 32){lfsr_q}};

  assign err_inc = (b_hs && (BRESP != RESP_OKAY)) ||
                   (r_hs && ((RRESP != RESP_OKAY) || (RDATA != pattern)));

  axi_tg_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (ACLK),
    .rst     (ARESET),
    .load    (lfsr_load),
    .advance (beat_adv),
    .state   (lfsr_q)
  );

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_go) state_nx = (sel_num == '0) ? ST_DONE : ST_AW_W;
      end
      ST_AW_W: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nx = ST_B;
        end else if (timed_out) begin
          state_nx = ST_DONE;
          tmo_hit  = 1'b1;
        end
      end
      ST_B: begin
        if (b_hs) begin
          state_nx = last_beat ? ST_RD_INIT : ST_AW_W;
        end else if (timed_out) begin
          state_nx = ST_DONE;
          tmo_hit  = 1'b1;
        end
      end
      ST_RD_INIT: state_nx = ST_AR;
      ST_AR: begin
        if (ar_hs) begin
          state_nx = ST_R;
        end else if (timed_out) begin
          state_nx = ST_DONE;
          tmo_hit  = 1'b1;
        end
      end
      ST_R: begin
        if (r_hs) begin
          state_nx = last_beat ? ST_DONE : ST_AR;
        end else if (timed_out) begin
          state_nx = ST_DONE;
          tmo_hit  = 1'b1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control state: sequencer, handshake tracking, counters, status.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      wait_cnt   <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      start_pend <= 1'b0;
    end else begin
      state <= state_nx;
      // Each channel's VALID drops the cycle after its own handshake.
      if ((state == ST_AW_W) && (state_nx == ST_AW_W)) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      wait_cnt <= (state_nx != state) ? '0 : wait_cnt + WAIT_W'(1);
      if (start_go || (state == ST_RD_INIT)) idx_q <= '0;
      else if (beat_adv) idx_q <= idx_q + CNT_W'(1);
      if (state_nx == ST_DONE) done_q <= 1'b1;
      else if (start_go) done_q <= 1'b0;
      if (start_go) timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
      if (start_go) err_q <= '0;
      else if (err_inc && (err_q != '1)) err_q <= err_q + ERR_W'(1);
      if ((state == ST_DONE) && start) start_pend <= 1'b1;
      else if (state == ST_IDLE) start_pend <= 1'b0;
    end
  end

  // Address/parameter registers: no reset, outputs are gated by state.
  always_ff @(posedge ACLK) begin
    if (start_go) begin
      base_q <= sel_base;
      num_q  <= sel_num;
      addr_q <= sel_base;
    end else if ((state == ST_DONE) && start) begin
      base_q <= base_addr;
      num_q  <= num_txn;
    end else if (state == ST_RD_INIT) begin
      addr_q <= base_q;
    end else if (beat_adv) begin
      addr_q <= addr_q + ADDR_W'(STRIDE);
    end
  end

  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = done_q;
  assign pass    = done_q && (err_q == '0) && !timeout_q;
  assign timeout = timeout_q;
  assign err_cnt = err_q;

  assign AWVALID = (state == ST_AW_W) && !aw_done;
  assign WVALID  = (state == ST_AW_W) && !w_done;
  assign BREADY  = (state == ST_B);
  assign ARVALID = (state == ST_AR);
  assign RREADY  = (state == ST_R);
  assign AWADDR  = (state == ST_AW_W) ? addr_q : '0;
  assign ARADDR  = (state == ST_AR) ? addr_q : '0;
  assign WDATA   = (state == ST_AW_W) ? pattern : '0;
  assign WSTRB   = '1;
  assign AWPROT  = 3'b000;
  assign ARPROT  = 3'b000;

endmodule

// File: tb/tb_axi_lite_traffic_checker.sv
// Directed bench for axi_lite_traffic_checker with a memory-backed
// subordinate model and an address/data scoreboard.
module tb_axi_lite_traffic_checker;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int EW = 16;
  localparam int TMO = 64;
  localparam logic [31:0] SEED_V = 32'hACE1_2468;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          ACLK, ARESET, start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_txn;
  logic          busy, done, pass, timeout;
  logic [EW-1:0] err_cnt;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  axi_lite_traffic_checker #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .ERR_W(EW),
                             .TIMEOUT_CYC(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
    .num_txn(num_txn), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_cnt(err_cnt),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference pattern generator: taps at 32, 22, 2, 1 in right-shift form.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] t;
    t = {1'b0, s[31:1]};
    if (s[0]) begin
      t[31] = ~t[31];
      t[21] = ~t[21];
      t[1]  = ~t[1];
      t[0]  = ~t[0];
    end
    return t;
  endfunction

  // Subordinate state and observation hooks
  logic [63:0] mem [int unsigned];
  bit          aw_got, w_got, ar_got;
  logic [31:0] aw_a, ar_a, cap_aw, cap_ar, prev_awaddr, prev_araddr;
  logic [63:0] w_d, cap_w;
  bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
  bit          prev_aw_wait, prev_ar_wait;
  bit          b_en = 1'b1;
  int          aw_stall = 0, ar_stall = 0, flip_beat = -1, rbeat = 0;
  int          aw_wait_cnt, ar_wait_cnt, b_wait_cnt;
  bit          w_first, any_valid;
  logic [31:0] exp_aw[$], exp_ar[$];
  logic [63:0] exp_w[$];

  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = OKAY;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = OKAY;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        aw_got = 0; w_got = 0; ar_got = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        prev_aw_wait = 0; prev_ar_wait = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        continue;
      end
      if (hs_aw) begin aw_got = 1; aw_a = cap_aw; end
      if (hs_w)  begin w_got = 1; w_d = cap_w; end
      if (hs_b)  BVALID = 0;
      if (hs_ar) begin ar_got = 1; ar_a = cap_ar; end
      if (hs_r)  begin RVALID = 0; rbeat++; end
      if (prev_aw_wait) begin
        chk("awvalid_held", AWVALID, 1);
        chk("awaddr_stable", AWADDR, prev_awaddr);
      end
      if (prev_ar_wait) begin
        chk("arvalid_held", ARVALID, 1);
        chk("araddr_stable", ARADDR, prev_araddr);
      end
      if (aw_got && w_got) begin
        if (aw_a < 32'h2000) begin mem[aw_a] = w_d; BRESP = OKAY; end
        else BRESP = SLVERR;
        if (b_en) BVALID = 1;
        aw_got = 0; w_got = 0;
      end
      if (ar_got && !RVALID) begin
        if (ar_a < 32'h2000) begin
          RDATA = mem.exists(ar_a) ? mem[ar_a] : 64'h0;
          RRESP = OKAY;
        end else begin
          RDATA = '0;
          RRESP = SLVERR;
        end
        if (rbeat == flip_beat) RDATA[0] = ~RDATA[0];
        RVALID = 1; ar_got = 0;
      end
      AWREADY = (aw_stall == 0) && !aw_got;
      if (AWVALID && aw_stall > 0) aw_stall--;
      WREADY = !w_got;
      ARREADY = (ar_stall == 0) && !ar_got;
      if (ARVALID && ar_stall > 0) ar_stall--;
      if (AWVALID || WVALID || ARVALID) any_valid = 1;
      if (AWVALID && !WVALID) w_first = 1;
      if (AWVALID && !AWREADY) aw_wait_cnt++;
      if (ARVALID && !ARREADY) ar_wait_cnt++;
      if (BREADY) b_wait_cnt++;
      prev_aw_wait = AWVALID && !AWREADY; prev_awaddr = AWADDR;
      prev_ar_wait = ARVALID && !ARREADY; prev_araddr = ARADDR;
      hs_aw = AWVALID && AWREADY; cap_aw = AWADDR;
      hs_w  = WVALID && WREADY;   cap_w  = WDATA;
      hs_b  = BVALID && BREADY;
      hs_ar = ARVALID && ARREADY; cap_ar = ARADDR;
      hs_r  = RVALID && RREADY;
      if (hs_aw) begin
        if (exp_aw.size() > 0) chk("awaddr", AWADDR, exp_aw.pop_front());
        else chk("aw_extra", exp_aw.size(), 1);
      end
      if (hs_w) begin
        if (exp_w.size() > 0) chk("wdata", WDATA, exp_w.pop_front());
        else chk("w_extra", exp_w.size(), 1);
      end
      if (hs_ar) begin
        if (exp_ar.size() > 0) chk("araddr", ARADDR, exp_ar.pop_front());
        else chk("ar_extra", exp_ar.size(), 1);
      end
    end
  end

  task automatic start_run(input logic [31:0] base, input int n);
    logic [31:0] s;
    repeat (2) @(negedge ACLK);
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    rbeat = 0; any_valid = 0; w_first = 0;
    aw_wait_cnt = 0; ar_wait_cnt = 0; b_wait_cnt = 0;
    s = SEED_V;
    for (int i = 0; i < n; i++) begin
      exp_aw.push_back(base + 32'(i * 8));
      exp_ar.push_back(base + 32'(i * 8));
      exp_w.push_back({s, s});
      s = model_step(s);
    end
    base_addr = base;
    num_txn = CW'(n);
    start = 1;
    @(negedge ACLK);
    start = 0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_end(input string tag, input int e, input bit p, input bit t);
    chk({tag, "_err_cnt"}, err_cnt, e);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_timeout"}, timeout, t);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_aw_left"}, exp_aw.size(), 0);
    chk({tag, "_w_left"}, exp_w.size(), 0);
    chk({tag, "_ar_left"}, exp_ar.size(), 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_valids"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    chk({tag, "_awaddr"}, AWADDR, 0);
    chk({tag, "_araddr"}, ARADDR, 0);
    chk({tag, "_wdata"}, WDATA, 0);
  endtask

  initial begin
    int cyc;
    int k;
    ARESET = 1; start = 0; base_addr = '0; num_txn = '0;
    repeat (3) @(negedge ACLK);
    check_quiet("reset");
    chk("reset_prot", {AWPROT, ARPROT}, 0);
    chk("reset_wstrb", WSTRB, 8'hFF);
    ARESET = 0;

    // Zero-wait write/read of four beats
    start_run(32'h100, 4);
    wait_done("basic", cyc);
    chk("basic_latency", cyc, 18);
    check_end("basic", 0, 1, 0);
    check_drained("basic");

    // Out-of-range region answers SLVERR on every beat
    start_run(32'h2000, 2);
    wait_done("slverr", cyc);
    check_end("slverr", 4, 0, 0);
    check_drained("slverr");

    // AWREADY stalled, W accepted first
    aw_stall = 5;
    start_run(32'h100, 2);
    wait_done("awstall", cyc);
    check_end("awstall", 0, 1, 0);
    chk("awstall_wait_cycles", aw_wait_cnt, 5);
    chk("awstall_w_first", w_first, 1);
    check_drained("awstall");

    // ARREADY stalled on the first read
    ar_stall = 10;
    start_run(32'h100, 2);
    wait_done("arstall", cyc);
    check_end("arstall", 0, 1, 0);
    chk("arstall_wait_cycles", ar_wait_cnt, 10);
    check_drained("arstall");

    // Corrupt one read beat
    flip_beat = 2;
    start_run(32'h100, 4);
    wait_done("flip", cyc);
    check_end("flip", 1, 0, 0);
    check_drained("flip");
    flip_beat = -1;

    // Write response never arrives
    b_en = 0;
    start_run(32'h100, 1);
    wait_done("btmo", cyc);
    check_end("btmo", 0, 0, 1);
    chk("btmo_b_cycles", b_wait_cnt, 64);
    chk("btmo_latency", cyc, 66);
    chk("btmo_bready", BREADY, 0);
    b_en = 1;

    // Empty run
    start_run(32'h100, 0);
    wait_done("zero", cyc);
    chk("zero_latency", cyc, 1);
    check_end("zero", 0, 1, 0);
    chk("zero_no_valid", any_valid, 0);

    // Reset during the read phase, then a clean re-run
    start_run(32'h100, 4);
    k = 0;
    while (!ARVALID && k < 200) begin
      @(negedge ACLK);
      k++;
    end
    chk("midrst_in_read", ARVALID, 1);
    ARESET = 1;
    @(negedge ACLK);
    check_quiet("midrst");
    @(negedge ACLK);
    ARESET = 0;
    start_run(32'h100, 4);
    wait_done("rerun", cyc);
    chk("rerun_latency", cyc, 18);
    check_end("rerun", 0, 1, 0);
    check_drained("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
